// File: rtl/mem_access_arbiter_if.sv
// Shared-RAM access bundle between the control unit, the arbiter and the RAM.
// The master side is the control unit plus RAM; the slave side is the arbiter.
interface mem_access_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_moc;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_rw;
  logic        d_byte;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_moc;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_rw;
  logic        mem_byte;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        owner;

  modport master (
    output if_req, if_addr, d_req, d_rw, d_byte, d_addr, d_wdata, mem_rdata,
    input  if_moc, if_rdata, d_moc, d_rdata, mem_en, mem_rw, mem_byte,
           mem_addr, mem_wdata, busy, owner
  );

  modport slave (
    input  if_req, if_addr, d_req, d_rw, d_byte, d_addr, d_wdata, mem_rdata,
    output if_moc, if_rdata, d_moc, d_rdata, mem_en, mem_rw, mem_byte,
           mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Single RAM port shared by instruction fetch and load/store, with a fixed wait-state count.
// Optional MEM_ROUND_ROBIN_EN alternates ownership on ties; default is data-over-fetch priority.
module mem_access_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic Clk,
  input  logic Reset,
  mem_access_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t     state;
  logic [3:0] cnt;
  logic       grant_data;

  function automatic logic [31:0] fmt_addr(input logic [31:0] a, input logic byt);
    return byt ? a : {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] fmt_byte(input logic [31:0] v, input logic byt);
    return byt ? {24'b0, v[7:0]} : v;
  endfunction

`ifdef MEM_ROUND_ROBIN_EN
  logic last_owner;

  // On a tie the requester that did not own the last completed access wins.
  always_comb grant_data = bus.d_req && (!bus.if_req || !last_owner);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      last_owner <= 1'b0;
    else if (state == DONE)
      last_owner <= bus.owner;
  end
`else
  always_comb grant_data = bus.d_req;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      bus.mem_en    <= 1'b0;
      bus.mem_rw    <= 1'b0;
      bus.mem_byte  <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      bus.if_moc    <= 1'b0;
      bus.d_moc     <= 1'b0;
      bus.if_rdata  <= 32'd0;
      bus.d_rdata   <= 32'd0;
      bus.busy      <= 1'b0;
      bus.owner     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            state      <= ACCESS;
            cnt        <= WAIT_INIT;
            bus.mem_en <= 1'b1;
            bus.busy   <= 1'b1;
            bus.owner  <= grant_data;
            if (grant_data) begin
              bus.mem_rw    <= bus.d_rw;
              bus.mem_byte  <= bus.d_byte;
              bus.mem_addr  <= fmt_addr(bus.d_addr, bus.d_byte);
              bus.mem_wdata <= fmt_byte(bus.d_wdata, bus.d_byte);
            end else begin
              bus.mem_rw    <= 1'b1;
              bus.mem_byte  <= 1'b0;
              bus.mem_addr  <= fmt_addr(bus.if_addr, 1'b0);
              bus.mem_wdata <= 32'd0;
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state      <= DONE;
            bus.mem_en <= 1'b0;
            if (bus.owner) begin
              bus.d_moc <= 1'b1;
              if (bus.mem_rw)
                bus.d_rdata <= fmt_byte(bus.mem_rdata, bus.mem_byte);
            end else begin
              bus.if_moc   <= 1'b1;
              bus.if_rdata <= bus.mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state      <= IDLE;
          bus.if_moc <= 1'b0;
          bus.d_moc  <= 1'b0;
          bus.busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter: directed plan cases, random traffic, reset abort.
module tb_mem_access_arbiter;
  localparam int W = 2;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  mem_access_arbiter_if bus();
  mem_access_arbiter #(.WAIT_CYCLES(W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic [31:0] ram [logic [31:0]];

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
  endfunction

  always @(negedge Clk) bus.mem_rdata = ram_word(bus.mem_addr);

  typedef struct {
    bit          own;
    logic [31:0] addr;
    bit          rw;
    bit          byt;
    logic [31:0] wdata;
    logic [31:0] ifr;
    logic [31:0] dr;
    int          start;
  } exp_t;

  exp_t q[$];
  logic [31:0] ifr_m = 32'd0;
  logic [31:0] dr_m  = 32'd0;
  bit          last_m = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference: one expected access for the given owner using the current request fields.
  function automatic void push_one(input bit own, input int start);
    exp_t e;
    logic [31:0] w;
    e.own = own;
    e.start = start;
    if (!own) begin
      e.addr = {bus.if_addr[31:2], 2'b00};
      e.rw = 1'b1;
      e.byt = 1'b0;
      e.wdata = 32'd0;
      ifr_m = ram_word(e.addr);
    end else begin
      e.rw = bus.d_rw;
      e.byt = bus.d_byte;
      e.addr = bus.d_byte ? bus.d_addr : {bus.d_addr[31:2], 2'b00};
      e.wdata = bus.d_byte ? {24'd0, bus.d_wdata[7:0]} : bus.d_wdata;
      if (e.rw) begin
        w = ram_word(e.addr);
        dr_m = e.byt ? {24'd0, w[7:0]} : w;
      end
    end
    e.ifr = ifr_m;
    e.dr = dr_m;
    last_m = own;
    q.push_back(e);
  endfunction

  // Called at a negedge with request fields already set.
  task automatic run_txn(input bit fe, input bit de, input bit redo);
    int n, start, budget, re_at;
    bit win, rd;
    start = cyc + 1;
    rd = 1'b0;
    if (fe && de) begin
`ifdef MEM_ROUND_ROBIN_EN
      win = !last_m;
`else
      win = 1'b1;
`endif
      push_one(win, start);
      push_one(!win, start + W + 3);
      n = 2;
      if (redo && win) begin
        push_one(1'b1, start + 2 * (W + 3));
        n = 3;
        rd = 1'b1;
      end
    end else begin
      push_one(de, start);
      n = 1;
    end
    bus.if_req = fe;
    bus.d_req = de;
    re_at = -1;
    budget = 0;
    while (n > 0 && budget < 20 * (W + 3)) begin
      @(negedge Clk);
      budget++;
      if (re_at > 0 && cyc == re_at) bus.d_req = 1'b1;
      if (bus.if_moc) begin bus.if_req = 1'b0; n--; end
      if (bus.d_moc) begin
        bus.d_req = 1'b0;
        n--;
        if (rd && re_at < 0) re_at = cyc + 2;
      end
      if (!fe) bus.if_addr = $urandom;
      if (!de) begin
        bus.d_addr = $urandom;
        bus.d_wdata = $urandom;
        bus.d_rw = 1'($urandom_range(0, 1));
        bus.d_byte = 1'($urandom_range(0, 1));
      end
    end
    if (n > 0) begin
      checks++;
      failures++;
      $display("FAIL txn_timeout outstanding=%0d required=0", n);
      bus.if_req = 1'b0;
      bus.d_req = 1'b0;
    end
  endtask

  // Monitor: compares each completed access against the scoreboard head.
  initial begin : monitor
    bit prev_en;
    int en_cnt;
    bit stable;
    logic [31:0] c_addr, c_wd;
    bit c_rw, c_byt;
    exp_t e;
    prev_en = 1'b0;
    en_cnt = 0;
    stable = 1'b1;
    c_addr = '0; c_wd = '0; c_rw = 1'b0; c_byt = 1'b0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        prev_en = 1'b0;
        en_cnt = 0;
        continue;
      end
      if (bus.mem_en && !prev_en) begin
        en_cnt = 1;
        stable = 1'b1;
        c_addr = bus.mem_addr; c_wd = bus.mem_wdata;
        c_rw = bus.mem_rw; c_byt = bus.mem_byte;
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_access actual=mem_en required=idle");
        end else begin
          check("start_cycle", cyc, q[0].start);
        end
      end else if (bus.mem_en) begin
        en_cnt++;
        if (bus.mem_addr !== c_addr || bus.mem_wdata !== c_wd ||
            bus.mem_rw !== c_rw || bus.mem_byte !== c_byt) stable = 1'b0;
      end
      if (bus.if_moc || bus.d_moc) begin
        check("moc_exclusive", {31'd0, bus.if_moc & bus.d_moc}, 32'd0);
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_moc actual=1 required=0");
        end else begin
          e = q.pop_front();
          check("moc_owner", {31'd0, bus.d_moc}, {31'd0, e.own});
          check("en_cycles", en_cnt, W + 1);
          check("en_fall", {30'd0, prev_en, bus.mem_en}, 32'd2);
          check("stable", {31'd0, stable}, 32'd1);
          check("mem_addr", c_addr, e.addr);
          check("mem_rw", {31'd0, c_rw}, {31'd0, e.rw});
          check("mem_byte", {31'd0, c_byt}, {31'd0, e.byt});
          if (!e.rw) check("mem_wdata", c_wd, e.wdata);
          check("if_rdata", bus.if_rdata, e.ifr);
          check("d_rdata", bus.d_rdata, e.dr);
          check("busy_owner", {30'd0, bus.busy, bus.owner}, {30'd0, 1'b1, e.own});
        end
        en_cnt = 0;
      end
      prev_en = bus.mem_en;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin : driver
    ram[32'h0000_0004] = 32'hE3A01005;
    ram[32'h0000_002B] = 32'h11223344;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_rw = 1'b0; bus.d_byte = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(negedge Clk);
    check("rst_ctrl", {27'd0, bus.mem_en, bus.if_moc, bus.d_moc, bus.busy, bus.owner}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_rdata", bus.if_rdata | bus.d_rdata, 32'd0);
    check("rst_rw_byte", {30'd0, bus.mem_rw, bus.mem_byte}, 32'd0);
    Reset = 1'b0;

    // Tie, data re-requests while fetch is served: data, fetch, data.
    @(negedge Clk);
    bus.if_addr = 32'h0000_0040;
    bus.d_addr = 32'h0000_0081; bus.d_rw = 1'b1; bus.d_byte = 1'b0;
    run_txn(1'b1, 1'b1, 1'b1);

    @(negedge Clk);
    bus.if_addr = 32'h0000_0006;
    run_txn(1'b1, 1'b0, 1'b0);

    @(negedge Clk);
    bus.d_rw = 1'b1; bus.d_byte = 1'b1; bus.d_addr = 32'h0000_002B;
    run_txn(1'b0, 1'b1, 1'b0);

    @(negedge Clk);
    bus.d_rw = 1'b0; bus.d_byte = 1'b1; bus.d_addr = 32'h0000_0101;
    bus.d_wdata = 32'hAABBCCDD;
    run_txn(1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      int kind;
      @(negedge Clk);
      kind = $urandom_range(0, 2);
      bus.if_addr = $urandom;
      bus.d_addr = $urandom;
      bus.d_wdata = $urandom;
      bus.d_rw = 1'($urandom_range(0, 1));
      bus.d_byte = 1'($urandom_range(0, 1));
      run_txn(kind != 1, kind != 0, 1'($urandom_range(0, 1)));
    end

    // Reset in the second ACCESS cycle abandons the fetch; it restarts after release.
    @(negedge Clk);
    bus.if_addr = 32'h0000_0206;
    push_one(1'b0, cyc + 1);
    bus.if_req = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("abort_ctrl", {27'd0, bus.mem_en, bus.if_moc, bus.d_moc, bus.busy, bus.owner}, 32'd0);
    check("abort_mem_addr", bus.mem_addr, 32'd0);
    check("abort_rdata", bus.if_rdata | bus.d_rdata, 32'd0);
    void'(q.pop_back());
    ifr_m = 32'd0; dr_m = 32'd0; last_m = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    run_txn(1'b1, 1'b0, 1'b0);

    repeat (W + 4) @(negedge Clk);
    check("queue_empty", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Arbitrates the single shared RAM port between the control unit's instruction-fetch path and its load/store data path. Each access is sequenced through a fixed wait-state count, and a one-cycle MOC (memory operation complete) pulse goes back to the requester that owns the access. The block sits between the control unit and RAM. It provides the MOC that the fetch wait state (state 3) and the LDR/STR/LDRB/STRB states of the next-state decoder poll.

## Interface
- WAIT_CYCLES, 2, extra RAM cycles per access beyond the first; legal range 0..15
- Clk  in  1  system clock; all state changes on the rising edge
- Reset  in  1  asynchronous, active-high
- if_req  in  1  fetch request; held high until if_moc
- if_addr  in  32  fetch byte address
- if_moc  out  1  one-cycle fetch-complete pulse
- if_rdata  out  32  fetched word; holds until the next fetch completes
- d_req  in  1  data request; held high until d_moc
- d_rw  in  1  1 = read (LDR/LDRB), 0 = write (STR/STRB)
- d_byte  in  1  1 = byte access, 0 = word access
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_moc  out  1  one-cycle data-complete pulse
- d_rdata  out  32  load data; holds until the next data read completes
- mem_en  out  1  RAM enable
- mem_rw  out  1  1 = read, 0 = write
- mem_byte  out  1  byte access to RAM
- mem_addr  out  32  RAM address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data; byte reads are returned in [7:0]
- busy  out  1  high in ACCESS and DONE
- owner  out  1  0 = fetch, 1 = data; valid while busy

## Operation
- FSM with three states: IDLE, ACCESS, DONE.
- IDLE:
  - If any request is high, the arbiter picks an owner, latches its rw, byte, addr and wdata, loads wait counter = WAIT_CYCLES, and goes to ACCESS.
  - A fetch always latches rw=1 and byte=0.
- Arbitration is fixed priority: data beats fetch. With both requests high, data wins. See Configuration for the alternative.
- ACCESS:
  - mem_en=1, and the mem_* outputs are driven from the latched values, stable for the whole state.
  - The counter decrements each cycle. When the counter is 0, the arbiter captures mem_rdata (reads only) into the owner's rdata register and goes to DONE.
- DONE:
  - The owner's moc is high for exactly one cycle, mem_en=0, then back to IDLE.
- Address rules:
  - Word access: mem_addr = {addr[31:2], 2'b00}.
  - Byte access: full address is passed through.
- Data rules:
  - Byte write: mem_wdata = {24'b0, d_wdata[7:0]}.
  - Byte read: d_rdata = {24'b0, mem_rdata[7:0]}.
- Writes leave d_rdata unchanged.
- A request still high in the IDLE cycle after DONE starts a new access. Requesters must drop req in the cycle after moc.
- Request inputs are ignored during ACCESS and DONE. Changes to the non-owner's inputs have no effect.

## Timing
- Reset values: all outputs 0; rdata registers 0; state IDLE; counter 0.
- Reset mid-access abandons the access: mem_en drops asynchronously and no moc is issued.
- Latency: req sampled at edge N → mem_en high for cycles N+1 .. N+1+WAIT_CYCLES → moc high in cycle N+2+WAIT_CYCLES → IDLE at N+3+WAIT_CYCLES.
- WAIT_CYCLES=0 gives one ACCESS cycle, and moc arrives 2 cycles after the sampling edge.
- Minimum spacing between back-to-back accesses: WAIT_CYCLES+3 cycles.
- if_moc and d_moc are never high in the same cycle.
- rdata is valid in the same cycle as moc.

## Configuration
- MEM_ROUND_ROBIN_EN defined:
  - On simultaneous requests in IDLE, the requester that did not own the last completed access wins.
  - A 1-bit last-owner register resets to 0 (fetch), so the first tie goes to data.
  - A single requester is always granted immediately.
- MEM_ROUND_ROBIN_EN undefined: fixed priority, data over fetch. No last-owner register is present.

## Test plan
- WAIT_CYCLES=2, fetch-only read: if_addr=0x00000006, mem_rdata=0xE3A01005 → mem_addr=0x00000004, mem_en high for 3 cycles, if_moc in cycle 4 after the sampling edge, if_rdata=0xE3A01005.
- Byte load: d_rw=1, d_byte=1, d_addr=0x0000002B, mem_rdata=0x11223344 → mem_addr=0x0000002B, mem_byte=1, d_rdata=0x00000044, if_moc stays 0.
- Byte store: d_rw=0, d_byte=1, d_wdata=0xAABBCCDD → mem_rw=0, mem_wdata=0x000000DD, d_moc pulse, d_rdata unchanged.
- Fixed priority (macro off): if_req and d_req rise together and stay high → data access first, then fetch, then data. Gaps between moc pulses are 5 cycles (WAIT_CYCLES=2).
- Round robin (macro on): three consecutive tie cycles → owner sequence data, fetch, data.
- Reset asserted in the second ACCESS cycle → all outputs 0 immediately, no moc. After release, a pending if_req restarts with full latency.
